// File: rtl/mem_if.sv
// BusPkg holds the bus default widths; BusItf carries one word access per cycle.
package BusPkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
endpackage

interface BusItf #(
    parameter int ADDR_W = BusPkg::ADDR_W_DEF,
    parameter int DATA_W = BusPkg::DATA_W_DEF
) ();
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] dataM2S;
    logic [DATA_W-1:0] dataS2M;

    modport master (output addr, output we, output dataM2S, input dataS2M);
    modport slave  (input addr, input we, input dataM2S, output dataS2M);
endinterface

// File: rtl/mem.sv
// mem: DEPTH x DATA_W single-port word memory behind a BusItf slave port.
// Define MEM_REG_READ_EN for a registered, read-first read path (1-cycle latency).
module mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2**ADDR_W
) (
    input logic  clk,
    input logic  rst,
    BusItf.slave bBusIf
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Power-up contents are zero; reset never touches the array.
    logic [DATA_W-1:0] mem_array [DEPTH] = '{default: '0};

    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] rd_word;

    assign in_range = ({1'b0, bBusIf.addr} < DEPTH_LIM);
    assign idx      = bBusIf.addr[IDX_W-1:0];
    assign rd_word  = in_range ? mem_array[idx] : '0;

    always_ff @(posedge clk) begin
        if (bBusIf.we && in_range) begin
            mem_array[idx] <= bBusIf.dataM2S;
        end
    end

`ifdef MEM_REG_READ_EN
    logic [DATA_W-1:0] read_q;

    // Samples the pre-write word, so a same-cycle write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_q <= '0;
        end else begin
            read_q <= rd_word;
        end
    end

    assign bBusIf.dataS2M = read_q;
`else
    logic unused_rst;

    assign unused_rst     = rst;
    assign bBusIf.dataS2M = rd_word;
`endif

endmodule

// File: tb/tb_mem.sv
// Directed testbench for mem in its default (combinational read) build.
module tb_mem;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    BusItf #(.ADDR_W(8), .DATA_W(32)) bus ();

    mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut (
        .clk    (clk),
        .rst    (rst),
        .bBusIf (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we      = 1'b1;
        bus.addr    = a;
        bus.dataM2S = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic set_read(input logic [7:0] a);
        @(negedge clk);
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_read(8'h00);
        vectors++;
        if (bus.dataS2M !== 32'h0) begin
            $display("[TB] FAIL reset_read_00 got %h want %h", bus.dataS2M, 32'h0);
            miscompares++;
        end
        set_read(8'h80);
        vectors++;
        if (bus.dataS2M !== 32'h0) begin
            $display("[TB] FAIL reset_read_80 got %h want %h", bus.dataS2M, 32'h0);
            miscompares++;
        end
    endtask

    task automatic test_write_under_reset;
        rst = 1'b1;
        do_write(8'hFF, 32'hFFFF_FFFF);
        set_read(8'hFF);
        vectors++;
        if (bus.dataS2M !== 32'hFFFF_FFFF) begin
            $display("[TB] FAIL write_under_reset got %h want %h", bus.dataS2M, 32'hFFFF_FFFF);
            miscompares++;
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        do_write(8'h00, 32'h1234_5678);
        do_write(8'hFF, 32'hA5A5_A5A5);
        set_read(8'h00);
        vectors++;
        if (bus.dataS2M !== 32'h1234_5678) begin
            $display("[TB] FAIL basic_read_00 got %h want %h", bus.dataS2M, 32'h1234_5678);
            miscompares++;
        end
        set_read(8'hFF);
        vectors++;
        if (bus.dataS2M !== 32'hA5A5_A5A5) begin
            $display("[TB] FAIL basic_read_ff got %h want %h", bus.dataS2M, 32'hA5A5_A5A5);
            miscompares++;
        end
        set_read(8'h01);
        vectors++;
        if (bus.dataS2M !== 32'h0) begin
            $display("[TB] FAIL basic_read_01 got %h want %h", bus.dataS2M, 32'h0);
            miscompares++;
        end
    endtask

    task automatic test_no_write;
        @(negedge clk);
        bus.we      = 1'b0;
        bus.addr    = 8'h10;
        bus.dataM2S = 32'hDEAD_BEEF;
        @(posedge clk);
        set_read(8'h10);
        vectors++;
        if (bus.dataS2M !== 32'h0) begin
            $display("[TB] FAIL no_write_fresh got %h want %h", bus.dataS2M, 32'h0);
            miscompares++;
        end
        do_write(8'h10, 32'h1111_1111);
        @(negedge clk);
        bus.we      = 1'b0;
        bus.addr    = 8'h10;
        bus.dataM2S = 32'hDEAD_BEEF;
        @(posedge clk);
        set_read(8'h10);
        vectors++;
        if (bus.dataS2M !== 32'h1111_1111) begin
            $display("[TB] FAIL no_write_held got %h want %h", bus.dataS2M, 32'h1111_1111);
            miscompares++;
        end
    endtask

    task automatic test_reset_pulse;
        do_write(8'hFF, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_read(8'hFF);
        vectors++;
        if (bus.dataS2M !== 32'hFFFF_FFFF) begin
            $display("[TB] FAIL reset_pulse_ff got %h want %h", bus.dataS2M, 32'hFFFF_FFFF);
            miscompares++;
        end
        set_read(8'h00);
        vectors++;
        if (bus.dataS2M !== 32'h1234_5678) begin
            $display("[TB] FAIL reset_pulse_00 got %h want %h", bus.dataS2M, 32'h1234_5678);
            miscompares++;
        end
    endtask

    // Address changes within one low phase must show through with no clock edge.
    task automatic test_comb_read;
        @(negedge clk);
        bus.we   = 1'b0;
        bus.addr = 8'h00;
        #1;
        vectors++;
        if (bus.dataS2M !== 32'h1234_5678) begin
            $display("[TB] FAIL comb_read_00 got %h want %h", bus.dataS2M, 32'h1234_5678);
            miscompares++;
        end
        bus.addr = 8'h10;
        #1;
        vectors++;
        if (bus.dataS2M !== 32'h1111_1111) begin
            $display("[TB] FAIL comb_read_10 got %h want %h", bus.dataS2M, 32'h1111_1111);
            miscompares++;
        end
        bus.addr = 8'hFF;
        #1;
        vectors++;
        if (bus.dataS2M !== 32'hFFFF_FFFF) begin
            $display("[TB] FAIL comb_read_ff got %h want %h", bus.dataS2M, 32'hFFFF_FFFF);
            miscompares++;
        end
    endtask

    task automatic test_read_during_write;
        @(negedge clk);
        bus.we      = 1'b1;
        bus.addr    = 8'h30;
        bus.dataM2S = 32'hCAFE_F00D;
        #1;
        vectors++;
        if (bus.dataS2M !== 32'h0) begin
            $display("[TB] FAIL rdw_before got %h want %h", bus.dataS2M, 32'h0);
            miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.dataS2M !== 32'hCAFE_F00D) begin
            $display("[TB] FAIL rdw_after got %h want %h", bus.dataS2M, 32'hCAFE_F00D);
            miscompares++;
        end
        bus.we = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0]  addrs [5] = '{8'h40, 8'h40, 8'h40, 8'h41, 8'h42};
        logic [31:0] datas [5] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
                                   32'h4141_4141, 32'h4242_4242};
        logic [7:0]  raddr [3] = '{8'h40, 8'h41, 8'h42};
        logic [31:0] rexp  [3] = '{32'h0000_0003, 32'h4141_4141, 32'h4242_4242};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.we      = 1'b1;
            bus.addr    = addrs[i];
            bus.dataM2S = datas[i];
            @(negedge clk);
        end
        bus.we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_read(raddr[i]);
            vectors++;
            if (bus.dataS2M !== rexp[i]) begin
                $display("[TB] FAIL b2b_read_%h got %h want %h", raddr[i], bus.dataS2M, rexp[i]);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.we      = 1'b0;
        bus.addr    = '0;
        bus.dataM2S = '0;
        test_reset();
        test_write_under_reset();
        test_basic();
        test_no_write();
        test_reset_pulse();
        test_comb_read();
        test_read_during_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL be the word-address width of bus field addr.
REQ-002 Parameter DATA_W, default 32, SHALL be the width of bus data fields dataM2S and dataS2M.
REQ-003 Parameter DEPTH, default 2**ADDR_W (256), SHALL be the number of DATA_W-bit words stored.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high (only effect per REQ-016).
REQ-006 Port bBusIf, slave modport of BusPkg interface BusItf, carrying fields REQ-007..REQ-010.
REQ-007 bBusIf.addr, input, ADDR_W: word address.
REQ-008 bBusIf.we, input, 1 bit: write enable, active-high.
REQ-009 bBusIf.dataM2S, input, DATA_W: write data from master.
REQ-010 bBusIf.dataS2M, output, DATA_W: read data to master.

Function
REQ-011 Storage SHALL be a DEPTH x DATA_W array with no byte enables; each access addresses one full word.
REQ-012 On a rising clk edge with we=1, mem[addr] SHALL be set to dataM2S; with we=0 no word changes.
REQ-013 Default build: dataS2M SHALL equal mem[addr] combinationally, with zero-cycle latency from an addr change.
REQ-014 Read during write, default build: before the edge dataS2M shows the old word; after the edge it shows the new word.
REQ-015 No handshake: every cycle is a valid access; no ready/valid/wait states.
REQ-016 Writes and reads SHALL proceed identically whether rst is 0 or 1; rst never blocks or corrupts array access.
REQ-017 Addresses >= DEPTH (only when DEPTH < 2**ADDR_W) SHALL be ignored on write and return 0 on read.
REQ-018 All array words SHALL initialise to 0 at time zero (simulation init / FPGA bitstream init).
REQ-019 Consecutive writes to the same address SHALL leave the last value written.

Reset
REQ-020 rst SHALL NOT clear or modify the array contents.
REQ-021 Default build: rst SHALL have no observable effect.
REQ-022 With MEM_REG_READ_EN: the read register SHALL load 0 on any rising edge with rst=1, overriding the array read.

Configuration
REQ-023 Macro MEM_REG_READ_EN defined: dataS2M SHALL come from a register loaded with mem[addr] on each rising edge (1-cycle latency).
REQ-024 MEM_REG_READ_EN read during write: the register SHALL capture the old word (read-first).
REQ-025 MEM_REG_READ_EN undefined: behaviour per REQ-013/REQ-014 (combinational read).

Verification
REQ-026 Default build, rst=1 held: write we=1, addr=0xFF, data=0xFFFFFFFF for one cycle; next cycle we=0, addr=0xFF -> dataS2M=0xFFFFFFFF.
REQ-027 Write 0x12345678 to addr 0x00 and 0xA5A5A5A5 to addr 0xFF -> reads return 0x12345678 and 0xA5A5A5A5 respectively.
REQ-028 we=0, dataM2S=0xDEADBEEF, addr=0x10 for a cycle -> read of 0x10 returns its prior value (0 after power-up).
REQ-029 Pulse rst after writing 0xFFFFFFFF to 0xFF -> read of 0xFF still returns 0xFFFFFFFF.
REQ-030 MEM_REG_READ_EN, rst=0: write 0x55AA55AA to 0x20 -> dataS2M=0x55AA55AA exactly one edge after addr=0x20 is presented.
REQ-031 MEM_REG_READ_EN: rst=1 for one edge -> dataS2M=0 next cycle; with rst=0, the following edge restores the array word.
